// File: rtl/adder_new_pkg.sv
// Shared defaults and operand/result types for the registered 6-bit lookahead adder.
package adder_new_pkg;

  localparam int unsigned WIDTH_DEFAULT = 6;
  localparam int unsigned GROUP_DEFAULT = 3;

  typedef logic [WIDTH_DEFAULT-1:0] operand_t;
  typedef logic [WIDTH_DEFAULT:0]   result_t;

endpackage

// File: rtl/adder_new_cla_core.sv
// Combinational carry-lookahead adder core: X,Y -> {cout,S}, no carry-in.
module adder_new_cla_core
  import adder_new_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned GROUP = GROUP_DEFAULT
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  // WIDTH must be a multiple of GROUP; any remainder bits would be left unsummed.
  localparam int unsigned NumGroups = WIDTH / GROUP;

  logic [WIDTH-1:0]     g;
  logic [WIDTH-1:0]     p;
  logic [NumGroups-1:0] grp_g;
  logic [NumGroups-1:0] grp_p;
  logic [NumGroups:0]   grp_c;

  assign g = x_i & y_i;
  assign p = x_i ^ y_i;

  // Group generate/propagate over GROUP bits each.
  always_comb begin
    logic gacc;
    logic pacc;
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < int'(NumGroups); k++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int i = 0; i < int'(GROUP); i++) begin
        gacc = g[k*GROUP+i] | (p[k*GROUP+i] & gacc);
        pacc = pacc & p[k*GROUP+i];
      end
      grp_g[k] = gacc;
      grp_p[k] = pacc;
    end
  end

  // Group-level lookahead chain: c[k+1] = G[k] | P[k] & c[k], c[0] = 0.
  always_comb begin
    logic cc;
    grp_c = '0;
    cc    = 1'b0;
    for (int k = 0; k < int'(NumGroups); k++) begin
      cc           = grp_g[k] | (grp_p[k] & cc);
      grp_c[k+1]   = cc;
    end
  end

  // Bit carries inside a group start from that group's lookahead carry-in.
  always_comb begin
    logic cb;
    sum_o = '0;
    for (int k = 0; k < int'(NumGroups); k++) begin
      cb = grp_c[k];
      for (int i = 0; i < int'(GROUP); i++) begin
        sum_o[k*GROUP+i] = p[k*GROUP+i] ^ cb;
        cb = g[k*GROUP+i] | (p[k*GROUP+i] & cb);
      end
    end
  end

  assign cout_o = grp_c[NumGroups];

endmodule

// File: rtl/adder_new_6b.sv
// Registered 6-bit unsigned adder: captures X+Y on in_valid, one cycle of latency.
module adder_new_6b
  import adder_new_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned GROUP = GROUP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] core_sum;
  logic             core_cout;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             valid_d, valid_q;

  adder_new_cla_core #(
    .WIDTH (WIDTH),
    .GROUP (GROUP)
  ) u_cla_core (
    .x_i    (X),
    .y_i    (Y),
    .sum_o  (core_sum),
    .cout_o (core_cout)
  );

  // Mux on in_valid so X/Z operands never reach the result registers when idle.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    valid_d = 1'b0;
    if (in_valid) begin
      s_d     = core_sum;
      cout_d  = core_cout;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign S         = s_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_adder_new_6b.sv
// Directed and exhaustive checks for the registered 6-bit lookahead adder.
module tb_adder_new_6b;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] X;
  logic [5:0] Y;
  logic [5:0] S;
  logic       cout;
  logic       out_valid;

  int total;
  int bad;

  adder_new_6b #(
    .WIDTH (6),
    .GROUP (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .X         (X),
    .Y         (Y),
    .S         (S),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    X        = '0;
    Y        = '0;
    #2;
    total++;
    if ({S, cout, out_valid} !== 8'h00) begin
      bad++;
      $display("FAIL reset_initial: got S=%0d cout=%b ov=%b, want 0 0 0", S, cout, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Make the outputs nonzero, then reset asynchronously mid-cycle.
    X = 6'd50; Y = 6'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (S !== 6'd6 || cout !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_preload: got S=%0d cout=%b ov=%b, want 6 1 1", S, cout, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (S !== 6'd0 || cout !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got S=%0d cout=%b ov=%b, want 0 0 0", S, cout, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_corners();
    logic [5:0] xs [4] = '{6'd0, 6'd21, 6'd63, 6'd63};
    logic [5:0] ys [4] = '{6'd0, 6'd42, 6'd1, 6'd63};
    logic [5:0] es [4] = '{6'b000000, 6'b111111, 6'b000000, 6'b111110};
    logic       ec [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      X = xs[i]; Y = ys[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (S !== es[i] || cout !== ec[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL corner_%0d: %0d+%0d got S=%b cout=%b ov=%b, want S=%b cout=%b ov=1",
                 i, xs[i], ys[i], S, cout, out_valid, es[i], ec[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [6:0] exp_prev;
    int         errs;
    errs     = 0;
    exp_prev = '0;
    for (int i = 0; i <= 4096; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if ({cout, S} !== exp_prev || out_valid !== 1'b1) begin
          bad++;
          errs++;
          $display("FAIL exhaustive idx=%0d: got {cout,S}=%0d ov=%b, want %0d ov=1",
                   i - 1, {cout, S}, out_valid, exp_prev);
        end
      end
      if (i < 4096) begin
        X        = i[11:6];
        Y        = i[5:0];
        in_valid = 1'b1;
        exp_prev = {1'b0, i[11:6]} + {1'b0, i[5:0]};
      end else begin
        in_valid = 1'b0;
      end
    end
    $display("exhaustive sweep: %0d errors over 4096 pairs", errs);
  endtask

  task automatic test_hold();
    @(negedge clk);
    X = 6'd10; Y = 6'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    X = 6'd63; Y = 6'd63;
    total++;
    if (S !== 6'd30 || cout !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_capture: got S=%0d cout=%b ov=%b, want 30 0 1", S, cout, out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        X = 'x; Y = 'z;
      end
      @(negedge clk);
      total++;
      if (S !== 6'd30 || cout !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle_%0d: got S=%0d cout=%b ov=%b, want 30 0 0",
                 c, S, cout, out_valid);
      end
    end
    X = '0; Y = '0;
  endtask

  task automatic test_midstream_reset();
    @(negedge clk);
    X = 6'd40; Y = 6'd30; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (S !== 6'd6 || cout !== 1'b1 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_first: got S=%0d cout=%b ov=%b, want 6 1 1", S, cout, out_valid);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (S !== 6'd0 || cout !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_clear: got S=%0d cout=%b ov=%b, want 0 0 0", S, cout, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    X = 6'd5; Y = 6'd6; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (S !== 6'd11 || cout !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_after: got S=%0d cout=%b ov=%b, want 11 0 1", S, cout, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_c;
    exp_c = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if (cout !== exp_c || S !== 6'd0 || out_valid !== 1'b1) begin
          bad++;
          $display("FAIL throughput_%0d: got S=%0d cout=%b ov=%b, want 0 %b 1",
                   i - 1, S, cout, out_valid, exp_c);
        end
      end
      if (i < 6) begin
        in_valid = 1'b1;
        if (i % 2 == 0) begin
          X = 6'd63; Y = 6'd1; exp_c = 1'b1;
        end else begin
          X = 6'd0; Y = 6'd0; exp_c = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_corners();
    test_exhaustive();
    test_hold();
    test_midstream_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
